// File: rtl/bru_issue_sched.sv
// bru_issue_sched: in-order branch-op issue queue that holds each op until both source operands are ready
// Ports: CLK/RSTn clock and async active-low reset; flush discards everything queued or offered;
//   bru_dispat_* is the dispatch handshake (info, rs1, rs2); rf_ready holds per-register written-back flags;
//   bru_exeparam_* is the issue handshake to the BRU; bru_issue_cnt is the queue occupancy.
// Optional feature: define BRU_ISSUE_BYPASS_EN to issue an offered op in its dispatch cycle when the queue is empty.
`ifndef BRU_EXEPARAM_DW
`define BRU_EXEPARAM_DW 32
`endif
`ifndef RB
`define RB 1
`endif
module bru_issue_sched #(
    parameter int DW = `BRU_EXEPARAM_DW,
    parameter int DP = 4,
    parameter int RW = (5 + `RB)
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  flush,
    input  logic                  bru_dispat_vaild,
    input  logic [DW-1:0]         bru_dispat_info,
    input  logic [RW-1:0]         bru_dispat_rs1,
    input  logic [RW-1:0]         bru_dispat_rs2,
    output logic                  bru_dispat_ready,
    input  logic [(2**RW)-1:0]    rf_ready,
    output logic                  bru_exeparam_vaild,
    output logic [DW-1:0]         bru_exeparam,
    input  logic                  bru_exeparam_ready,
    output logic [$clog2(DP):0]   bru_issue_cnt
);
    localparam int AW = $clog2(DP);
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic [DW-1:0] info_q [DP];
    logic [DW-1:0] info_d [DP];
    logic [RW-1:0] rs1_q [DP];
    logic [RW-1:0] rs1_d [DP];
    logic [RW-1:0] rs2_q [DP];
    logic [RW-1:0] rs2_d [DP];
    logic [AW-1:0] head, tail;
    logic          empty, full, issuable, push, pop, byp;
    assign head     = rp_q[AW-1:0];
    assign tail     = wp_q[AW-1:0];
    assign empty    = wp_q == rp_q;
    assign full     = (head == tail) && (wp_q[AW] != rp_q[AW]);
    assign issuable = ~empty & rf_ready[rs1_q[head]] & rf_ready[rs2_q[head]];
    assign bru_dispat_ready = ~full & ~flush;
    assign bru_issue_cnt    = wp_q - rp_q;
`ifdef BRU_ISSUE_BYPASS_EN
    // An offered op with ready operands can go straight to the BRU while the queue is empty.
    assign byp = empty & bru_dispat_vaild & rf_ready[bru_dispat_rs1] & rf_ready[bru_dispat_rs2];
`else
    assign byp = 1'b0;
`endif
    assign bru_exeparam_vaild = (issuable | byp) & ~flush;
    assign bru_exeparam       = byp ? bru_dispat_info : info_q[head];
    assign pop  = bru_exeparam_vaild & bru_exeparam_ready & ~empty;
    // A bypassed op that the BRU takes immediately is never written into the queue.
    assign push = bru_dispat_vaild & bru_dispat_ready & ~(byp & bru_exeparam_ready);
    always_comb begin
        info_d = info_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        if (push) begin
            info_d[tail] = bru_dispat_info;
            rs1_d[tail]  = bru_dispat_rs1;
            rs2_d[tail]  = bru_dispat_rs2;
        end
        wp_d = flush ? '0 : wp_q + {{AW{1'b0}}, push};
        rp_d = flush ? '0 : rp_q + {{AW{1'b0}}, pop};
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wp_q   <= '0;
            rp_q   <= '0;
            info_q <= '{default: '0};
            rs1_q  <= '{default: '0};
            rs2_q  <= '{default: '0};
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            info_q <= info_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
        end
    end
endmodule

// File: tb/tb_bru_issue_sched.sv
// tb_bru_issue_sched: scoreboard bench for bru_issue_sched with directed vectors
module tb_bru_issue_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        dv = 1'b0;
    logic [31:0] dinfo = '0;
    logic [5:0]  rs1 = '0;
    logic [5:0]  rs2 = '0;
    logic        dready;
    logic [63:0] rf = '1;
    logic        ev;
    logic [31:0] einfo;
    logic        er = 1'b0;
    logic [2:0]  cnt;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] sb [$];
    bru_issue_sched dut (
        .CLK(clk), .RSTn(rst_n), .flush(flush),
        .bru_dispat_vaild(dv), .bru_dispat_info(dinfo),
        .bru_dispat_rs1(rs1), .bru_dispat_rs2(rs2), .bru_dispat_ready(dready),
        .rf_ready(rf), .bru_exeparam_vaild(ev), .bru_exeparam(einfo),
        .bru_exeparam_ready(er), .bru_issue_cnt(cnt)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (rst_n && ev && er) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got %h, expected no issue", einfo);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (einfo !== e) begin
                    n_fail++;
                    $display("FAIL issue_order: got %h, expected %h", einfo, e);
                end
            end
        end
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic offer(input logic [31:0] info, input logic [5:0] a, input logic [5:0] b);
        dv = 1'b1;
        dinfo = info;
        rs1 = a;
        rs2 = b;
    endtask
    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("drain_empty", 64'(sb.size()), 0);
    endtask
    initial begin
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_vaild", ev, 0);
        chk("rst_info", einfo, 0);
        chk("rst_dready", dready, 1);
        step();
        step();
        rst_n = 1'b1;
        // single op with ready operands
        er = 1'b1;
        offer(32'hA0A0_0001, 6'd3, 6'd5);
        sb.push_back(32'hA0A0_0001);
        #1;
        chk("t1_cnt0", cnt, 0);
`ifdef BRU_ISSUE_BYPASS_EN
        chk("t1_byp_vaild", ev, 1);
        step();
        dv = 1'b0;
        #1;
        chk("t1_cnt_byp", cnt, 0);
`else
        chk("t1_no_vaild", ev, 0);
        step();
        dv = 1'b0;
        #1;
        chk("t1_cnt1", cnt, 1);
        chk("t1_vaild", ev, 1);
        chk("t1_info", einfo, 32'hA0A0_0001);
`endif
        step();
        chk("t1_cnt_end", cnt, 0);
        // head blocked on an unready operand blocks the younger op
        rf[5] = 1'b0;
        offer(32'hB000_000A, 6'd3, 6'd5);
        sb.push_back(32'hB000_000A);
        step();
        offer(32'hB000_000B, 6'd1, 6'd2);
        sb.push_back(32'hB000_000B);
        step();
        dv = 1'b0;
        #1;
        chk("t2_cnt2", cnt, 2);
        chk("t2_blocked", ev, 0);
        step();
        chk("t2_still_blocked", ev, 0);
        rf[5] = 1'b1;
        #1;
        chk("t2_release_vaild", ev, 1);
        chk("t2_release_info", einfo, 32'hB000_000A);
        step();
        chk("t2_cnt1", cnt, 1);
        chk("t2_second_info", einfo, 32'hB000_000B);
        step();
        chk("t2_cnt0", cnt, 0);
        // fill, refuse when full, pointer wrap
        er = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(32'hC000_0000 + 32'(i), 6'd1, 6'd2);
            sb.push_back(32'hC000_0000 + 32'(i));
            step();
        end
        chk("t3_cnt4", cnt, 4);
        chk("t3_full_dready", dready, 0);
        offer(32'hC000_0004, 6'd1, 6'd2);
        step();
        chk("t3_fifth_refused", cnt, 4);
        er = 1'b1;
        #1;
        chk("t3_pop_no_dready", dready, 0);
        step();
        er = 1'b0;
        #1;
        chk("t3_cnt3", cnt, 3);
        chk("t3_dready_back", dready, 1);
        sb.push_back(32'hC000_0004);
        step();
        chk("t3_cnt4b", cnt, 4);
        dv = 1'b0;
        er = 1'b1;
        step();
        chk("t3_cnt3b", cnt, 3);
        offer(32'hC000_0005, 6'd1, 6'd2);
        sb.push_back(32'hC000_0005);
        step();
        dv = 1'b0;
        #1;
        chk("t3_pushpop_cnt", cnt, 3);
        drain();
        chk("t3_cnt_end", cnt, 0);
        // flush discards queued ops
        er = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'hD000_0000 + 32'(i), 6'd1, 6'd2);
            step();
        end
        dv = 1'b0;
        chk("t4_cnt3", cnt, 3);
        flush = 1'b1;
        er = 1'b1;
        #1;
        chk("t4_flush_vaild", ev, 0);
        chk("t4_flush_dready", dready, 0);
        step();
        flush = 1'b0;
        #1;
        chk("t4_cnt0", cnt, 0);
        chk("t4_no_stale", ev, 0);
        step();
        step();
        chk("t4_no_stale_later", ev, 0);
        // asynchronous reset between edges
        er = 1'b0;
        offer(32'hE000_0000, 6'd1, 6'd2);
        step();
        offer(32'hE000_0001, 6'd1, 6'd2);
        step();
        dv = 1'b0;
        chk("t5_cnt2", cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vaild", ev, 0);
        chk("t5_rst_cnt", cnt, 0);
        step();
        rst_n = 1'b1;
        er = 1'b1;
        offer(32'hF000_0001, 6'd1, 6'd2);
        sb.push_back(32'hF000_0001);
        step();
        dv = 1'b0;
        drain();
        step();
        chk("t5_cnt_end", cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bru_issue_sched.md
BRU_ISSUE_SCHED -- requirements
Module: bru_issue_sched

Interface
REQ-001 Parameter DW, default `BRU_EXEPARAM_DW; width of one branch exe-parameter word.
REQ-002 Parameter DP, default 4; queue depth; power of two, at least 2.
REQ-003 Parameter RW, default (5+`RB); width of a renamed register index.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RSTn  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  pipeline flush; discards all queued and offered ops.
REQ-007 bru_dispat_vaild  input  1  dispatch offers one branch op.
REQ-008 bru_dispat_info  input  DW  exe-parameter word of the offered op.
REQ-009 bru_dispat_rs1, bru_dispat_rs2  input  RW each  source indices of the offered op.
REQ-010 bru_dispat_ready  output  1  queue accepts the offered op this cycle.
REQ-011 rf_ready  input  2**RW  per-index operand-available flags, bit i means index i is written back.
REQ-012 bru_exeparam_vaild  output  1  head op offered to the BRU.
REQ-013 bru_exeparam  output  DW  exe-parameter word of the offered op.
REQ-014 bru_exeparam_ready  input  1  BRU accepts the op.
REQ-015 bru_issue_cnt  output  log2(DP)+1  current queue occupancy.

Function
REQ-016 The queue is an in-order FIFO of DP entries, each holding {info, rs1, rs2}; read and write pointers are log2(DP)+1 bits and wrap modulo 2*DP.
REQ-017 Empty means the pointers are equal; full means the index bits are equal and the wrap bits differ.
REQ-018 bru_dispat_ready = ~full & ~flush; it does not depend on a same-cycle pop.
REQ-019 Push occurs when bru_dispat_vaild & bru_dispat_ready; the entry is written at the write pointer and the write pointer increments.
REQ-020 Head is issuable when the queue is non-empty and rf_ready[head.rs1] and rf_ready[head.rs2] are both set.
REQ-021 bru_exeparam_vaild = issuable & ~flush, driven combinationally from registered head state; bru_exeparam = head.info.
REQ-022 Pop occurs when bru_exeparam_vaild & bru_exeparam_ready; the read pointer increments.
REQ-023 Issue is strictly in order; a non-issuable head blocks all younger entries.
REQ-024 Simultaneous push and pop in one cycle leaves occupancy unchanged; at most one push and one pop per cycle.
REQ-025 While full, a pop frees the slot for the next cycle only.
REQ-026 On flush, nothing issues or pushes in that cycle, and both pointers return to 0 at the next edge.
REQ-027 bru_issue_cnt = write pointer minus read pointer, modulo 2*DP; range 0..DP.
REQ-028 With the queue empty, the minimum latency from push to bru_exeparam_vaild is 1 cycle.

Reset
REQ-029 While RSTn=0: pointers are 0, every entry is zero, bru_exeparam_vaild=0, bru_exeparam=0, bru_issue_cnt=0, and bru_dispat_ready=1 (when flush=0).
REQ-030 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro BRU_ISSUE_BYPASS_EN, when defined, adds a bypass path; undefined, REQ-028 latency holds.
REQ-032 With the macro defined, when the queue is empty and the offered op has both operands ready:
- bru_exeparam_vaild=1 and bru_exeparam=bru_dispat_info in the same cycle.
- If bru_exeparam_ready=1, the op is consumed without being written and pointers are unchanged.
- Otherwise the op is pushed normally.
REQ-033 Flush suppresses the bypass path in the same way as normal issue.

Verification (DP=4)
REQ-034 Push A (rs1=3, rs2=5, both ready), ready=1 -> vaild=1 with info A one cycle later, popped; cnt goes 0,1,0; with the macro defined, vaild in the push cycle and cnt stays 0.
REQ-035 Push A (rf_ready[5]=0), then B (ready operands) -> neither issues; cnt=2; set rf_ready[5] -> A issues, then B next cycle.
REQ-036 Push 4 ops with ready held 0 -> cnt=4, bru_dispat_ready=0, 5th offer not accepted; one pop -> ready=1 next cycle; 6 total pushes exercise pointer wrap, output order preserved.
REQ-037 Full queue with simultaneous pop and new offer -> offer refused that cycle, cnt=3 next cycle.
REQ-038 3 entries queued, flush pulse -> vaild=0 and dispat_ready=0 in that cycle, cnt=0 next cycle, no stale op issues afterward.
REQ-039 RSTn driven low between edges with 2 entries queued -> vaild=0 and cnt=0 immediately; release -> normal push works.
